// File: rtl/calu_pkg.sv
// calu_pkg -- definitions shared by the sequential divider files.
//   CALU_WIDTH : default operand/result width
//   state_t    : divider controller states
package calu_pkg;

   localparam int CALU_WIDTH = 16;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/div_step.sv
// div_step -- one restoring-division iteration, purely combinational.
// Ports:
//   p      : partial remainder in (always < m_abs)
//   a      : dividend bits still to shift in; quotient bits fill from the LSB
//   m_abs  : divisor magnitude
//   p_nxt  : partial remainder out
//   a_nxt  : shifted dividend/quotient register with the new quotient bit
module div_step
   import calu_pkg::*;
#(
   parameter int WIDTH = CALU_WIDTH
) (
   input  logic [WIDTH-1:0] p,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] m_abs,
   output logic [WIDTH-1:0] p_nxt,
   output logic [WIDTH-1:0] a_nxt
);

   logic [WIDTH:0] p_sh;
   logic [WIDTH:0] diff;

   // p < m_abs <= 2^(WIDTH-1), so the shifted value always fits WIDTH+1 bits
   // and the restored value never needs its top bit.
   assign p_sh = {p, a[WIDTH-1]};
   assign diff = p_sh - {1'b0, m_abs};

   always_comb begin
      p_nxt = diff[WIDTH] ? p_sh[WIDTH-1:0] : diff[WIDTH-1:0];
      a_nxt = {a[WIDTH-2:0], ~diff[WIDTH]};
   end

endmodule

// File: rtl/signed_seq_divider.sv
// signed_seq_divider -- signed truncating divider, one quotient bit per cycle.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   start, Q, M  : request with dividend/divisor, taken only while idle
//   busy         : request in progress (through the done cycle)
//   done         : one-cycle pulse, results valid in that cycle
//   Quo, Rem     : signed quotient/remainder, held until the next result
//   DVF, ZE      : overflow (most-negative / -1), divide by zero
module signed_seq_divider
   import calu_pkg::*;
#(
   parameter int WIDTH = CALU_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic signed [WIDTH-1:0] Q,
   input  logic signed [WIDTH-1:0] M,
   output logic                    busy,
   output logic                    done,
   output logic signed [WIDTH-1:0] Quo,
   output logic signed [WIDTH-1:0] Rem,
   output logic                    DVF,
   output logic                    ZE
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic signed [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   state_t                  state;
   logic [CNT_W-1:0]        cnt;
   logic [WIDTH-1:0]        p_r, a_r, m_abs;
   logic [WIDTH-1:0]        p_nxt, a_nxt;
   logic signed [WIDTH-1:0] q_r;
   logic                    q_neg, m_neg, ze_r, dvf_r;
   logic                    is_ze, is_dvf;

   // Magnitude as an unsigned value; |most-negative| maps onto 2^(WIDTH-1).
   function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
      return v[WIDTH-1] ? (~v + 1'b1) : v;
   endfunction

   function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                   input logic neg);
      return neg ? (~v + 1'b1) : v;
   endfunction

   assign is_ze  = (M == '0);
   assign is_dvf = (Q == MOST_NEG) && (M == '1);

   div_step #(.WIDTH(WIDTH)) u_step (
      .p     (p_r),
      .a     (a_r),
      .m_abs (m_abs),
      .p_nxt (p_nxt),
      .a_nxt (a_nxt)
   );

   // Datapath registers: loaded on acceptance, iterated in CALC.
   always_ff @(posedge clk) begin
      if (state == S_IDLE && start) begin
         q_r   <= Q;
         q_neg <= Q[WIDTH-1];
         m_neg <= M[WIDTH-1];
         p_r   <= '0;
         a_r   <= mag(Q);
         m_abs <= mag(M);
         ze_r  <= is_ze;
         dvf_r <= is_dvf;
      end else if (state == S_CALC) begin
         p_r <= p_nxt;
         a_r <= a_nxt;
      end
   end

   // Controller and registered results.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         Quo   <= '0;
         Rem   <= '0;
         DVF   <= 1'b0;
         ZE    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  cnt   <= CNT_W'(WIDTH);
                  busy  <= 1'b1;
                  // Error cases skip the iterations entirely.
                  state <= (is_ze || is_dvf) ? S_FIX : S_CALC;
               end
            end
            S_CALC: begin
               cnt <= cnt - 1'b1;
               if (cnt == CNT_W'(1)) state <= S_FIX;
            end
            S_FIX: begin
               if (ze_r) begin
                  Quo <= '1;
                  Rem <= q_r;
               end else if (dvf_r) begin
                  Quo <= q_r;
                  Rem <= '0;
               end else begin
                  Quo <= apply_sign(a_r, q_neg ^ m_neg);
                  Rem <= apply_sign(p_r, q_neg);
               end
               ZE    <= ze_r;
               DVF   <= dvf_r & ~ze_r;
               done  <= 1'b1;
               state <= S_DONE;
            end
            S_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
